// File: rtl/cla4.sv
// 4-bit carry-lookahead adder with flattened carry equations and a registered result stage.
// Latency: s/c_out/c3/grp_p/grp_g/ovf combinational; s_q/c_out_q/ovf_q/out_valid one clk after in_valid.
// Backpressure: none; every in_valid cycle is captured. Optional macro CLA4_OVF_EN enables overflow logic.
module cla4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  input  logic       in_valid,
  output logic [3:0] s,
  output logic       c_out,
  output logic       c3,
  output logic       grp_p,
  output logic       grp_g,
  output logic       ovf,
  output logic [3:0] s_q,
  output logic       c_out_q,
  output logic       ovf_q,
  output logic       out_valid
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Per-bit propagate / generate terms.
  always_comb begin
    p = a ^ b;
    g = a & b;
  end

  // Every carry is a two-level sum of products of p, g and c_in; none depends on another carry.
  always_comb begin
    c[0] = c_in;
    c[1] = g[0]
         | (p[0] & c_in);
    c[2] = g[1]
         | (p[1] & g[0])
         | (p[1] & p[0] & c_in);
    c[3] = g[2]
         | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c_in);
    c[4] = g[3]
         | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c_in);
  end

  // Sum bits, carry outputs and group terms for cascading into a larger adder.
  always_comb begin
    s     = p ^ c[3:0];
    c_out = c[4];
    c3    = c[3];
    grp_p = p[3] & p[2] & p[1] & p[0];
    grp_g = g[3]
          | (p[3] & g[2])
          | (p[3] & p[2] & g[1])
          | (p[3] & p[2] & p[1] & g[0]);
  end

  logic [3:0] s_d;
  logic       c_out_d;
  logic       valid_q;

  // Capture the combinational result only on in_valid; otherwise hold the last one.
  always_comb begin
    s_d     = s_q;
    c_out_d = c_out_q;
    if (in_valid) begin
      s_d     = s;
      c_out_d = c_out;
    end
  end

  // Result register; reset clears immediately and overrides a same-cycle capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= 4'd0;
      c_out_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      c_out_q <= c_out_d;
      valid_q <= in_valid;
    end
  end

  assign out_valid = valid_q;

`ifdef CLA4_OVF_EN
  logic ovf_d;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_comb begin
    ovf   = c[4] ^ c[3];
    ovf_d = in_valid ? ovf : ovf_q;
  end

  // Registered overflow flag, captured alongside the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`else
  // Overflow logic not built; both flags are constant zero.
  always_comb begin
    ovf   = 1'b0;
    ovf_q = 1'b0;
  end
`endif

endmodule

// File: tb/tb_cla4.sv
// Bench for cla4: exhaustive combinational sweep, directed corner vectors, and a
// randomized registered-stage run checked through an expected-result queue.
// Reset behaviour (async clear, reset winning over capture) is exercised explicitly.
module tb_cla4;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       c_in;
  logic       in_valid;
  logic [3:0] s;
  logic       c_out;
  logic       c3;
  logic       grp_p;
  logic       grp_g;
  logic       ovf;
  logic [3:0] s_q;
  logic       c_out_q;
  logic       ovf_q;
  logic       out_valid;

  cla4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .s         (s),
    .c_out     (c_out),
    .c3        (c3),
    .grp_p     (grp_p),
    .grp_g     (grp_g),
    .ovf       (ovf),
    .s_q       (s_q),
    .c_out_q   (c_out_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid)
  );

  typedef struct {
    int s;
    int c_out;
    int ovf;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: plain integer arithmetic.
  function automatic int ref_sum(int x, int y, int ci);
    return x + y + ci;
  endfunction

  function automatic int ref_ovf(int x, int y, int ci);
    int sx, sy, t;
`ifdef CLA4_OVF_EN
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    t  = sx + sy + ci;
    return (t > 7 || t < -8) ? 1 : 0;
`else
    sx = x; sy = y; t = ci;
    return 0;
`endif
  endfunction

  function automatic exp_t ref_res(int x, int y, int ci);
    exp_t e;
    int t;
    t       = ref_sum(x, y, ci);
    e.s     = t % 16;
    e.c_out = t / 16;
    e.ovf   = ref_ovf(x, y, ci);
    return e;
  endfunction

  task automatic check_comb(int x, int y, int ci, string tag);
    exp_t e;
    e = ref_res(x, y, ci);
    chk({tag, "_sum"},   {27'd0, c_out, s}, ref_sum(x, y, ci));
    chk({tag, "_c3"},    int'(c3),    ((x % 8) + (y % 8) + ci) / 8);
    chk({tag, "_grp_p"}, int'(grp_p), ((x ^ y) == 15) ? 1 : 0);
    chk({tag, "_grp_g"}, int'(grp_g), (x + y) / 16);
    chk({tag, "_ovf"},   int'(ovf),   e.ovf);
  endtask

  // Drive one cycle of stimulus at the falling edge; queue the expected result if it should be captured.
  task automatic drive(int x, int y, int ci, bit v, bit expect_capture);
    @(negedge clk);
    a        = 4'(x);
    b        = 4'(y);
    c_in     = ci[0];
    in_valid = v;
    if (v && expect_capture) sb.push_back(ref_res(x, y, ci));
  endtask

  // Monitor: just after each rising edge, compare registered outputs with the queue or held value.
  always begin
    @(posedge clk);
    #1;
    if (!done) begin
      if (!rst_n) begin
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_s_q",       int'(s_q),       0);
        chk("rst_c_out_q",   int'(c_out_q),   0);
        chk("rst_ovf_q",     int'(ovf_q),     0);
        last = '{0, 0, 0};
      end else if (out_valid) begin
        chk("spurious_out_valid", (sb.size() != 0) ? 1 : 0, 1);
        if (sb.size() != 0) begin
          last = sb.pop_front();
          chk("reg_s_q",     int'(s_q),     last.s);
          chk("reg_c_out_q", int'(c_out_q), last.c_out);
          chk("reg_ovf_q",   int'(ovf_q),   last.ovf);
        end
      end else begin
        chk("missing_out_valid", sb.size(), 0);
        if (sb.size() != 0) void'(sb.pop_front());
        chk("hold_s_q",     int'(s_q),     last.s);
        chk("hold_c_out_q", int'(c_out_q), last.c_out);
        chk("hold_ovf_q",   int'(ovf_q),   last.ovf);
      end
    end
  end

  initial begin
    a = 0; b = 0; c_in = 0; in_valid = 0;
    last  = '{0, 0, 0};
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("por_out_valid", int'(out_valid), 0);
    chk("por_s_q",       int'(s_q),       0);
    chk("por_c_out_q",   int'(c_out_q),   0);
    chk("por_ovf_q",     int'(ovf_q),     0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Exhaustive combinational sweep with no captures.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int ci = 0; ci < 2; ci++) begin
          a = 4'(x); b = 4'(y); c_in = ci[0];
          #1;
          check_comb(x, y, ci, "exh");
        end

    // Directed corners.
    a = 4'b0111; b = 4'b0001; c_in = 0; #1;
    check_comb(7, 1, 0, "d_7p1");
`ifdef CLA4_OVF_EN
    chk("d_7p1_ovf_const", int'(ovf), 1);
`else
    chk("d_7p1_ovf_const", int'(ovf), 0);
`endif
    a = 4'b1111; b = 4'b0001; c_in = 0; #1;
    check_comb(15, 1, 0, "d_wrap");
    chk("d_wrap_s", int'(s), 0);
    chk("d_wrap_cout", int'(c_out), 1);
    chk("d_wrap_grp_g", int'(grp_g), 1);
    a = 4'b1010; b = 4'b0101; c_in = 1; #1;
    check_comb(10, 5, 1, "d_prop");
    chk("d_prop_grp_p", int'(grp_p), 1);

    // Registered stage: single pulse, then hold.
    drive(3, 4, 1, 1, 1);
    drive(0, 0, 0, 0, 0);
    @(posedge clk); #2;
    chk("pulse_s_q_value", int'(s_q), 8);
    chk("pulse_c_out_q_value", int'(c_out_q), 0);
    drive(9, 9, 0, 0, 0);
    drive(9, 9, 0, 0, 0);

    // Randomized back-to-back and gapped traffic.
    for (int i = 0; i < 300; i++)
      drive($urandom_range(15), $urandom_range(15), $urandom_range(1), ($urandom_range(3) != 0), 1);

    // Async reset mid-cycle after a capture; combinational path keeps tracking.
    drive(15, 15, 1, 1, 1);
    drive(6, 5, 0, 0, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("arst_s_q",       int'(s_q),       0);
    chk("arst_c_out_q",   int'(c_out_q),   0);
    chk("arst_ovf_q",     int'(ovf_q),     0);
    chk("arst_out_valid", int'(out_valid), 0);
    check_comb(6, 5, 0, "arst_comb");
    a = 4'd12; b = 4'd9; c_in = 1; #1;
    check_comb(12, 9, 1, "arst_comb2");

    // Reset held across a would-be capture: nothing is produced.
    drive(7, 7, 1, 1, 0);
    drive(7, 7, 1, 0, 0);
    rst_n = 1'b1;
    // First capture after reset release.
    drive(2, 13, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    repeat (3) drive(1, 1, 0, 0, 0);

    done = 1;
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
